instr_prefetch: RTL and testbench

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch.sv | 123 ++++++++++++
 tb/tb_instr_prefetch.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: pulls up to 10 bytes from a byte-wide memory
// starting at pc and presents them as Byte0 and Byte19.
// Ports:
//   clk, rst_n              clock and async active-low reset
//   pc, req                 fetch address and request (taken in IDLE or DONE)
//   mem_addr, mem_rd        memory read address and strobe
//   mem_rdata, mem_valid    returned byte and its qualifier
//   mem_err                 memory fault on the current beat
//   Byte0, Byte19           fetched instruction bytes
//   instr_ready, imem_error result complete, result faulted or invalid
//   busy                    fetch in progress
module instr_prefetch #(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] pc,
  input  logic        req,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_valid,
  input  logic        mem_err,
  output logic [7:0]  Byte0,
  output logic [71:0] Byte19,
  output logic        instr_ready,
  output logic        imem_error,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_t;

  state_t      state;
  logic [63:0] base;
  logic [3:0]  k;
  logic [3:0]  len;
  logic [64:0] addr_x;
  logic        oob;
  logic [3:0]  len0;
  logic        bad0;

  // 65-bit sum: the carry flags a wrap past 2^64-1, which also makes
  // the compare against MEM_SIZE fail.
  assign addr_x = {1'b0, base} + 65'(k);
  assign oob    = addr_x >= 65'(MEM_SIZE);

  // Strobe and address come straight from the state register so that an
  // asynchronous reset drops them at once and an out-of-range beat never
  // shows a read.
  assign busy     = (state == FETCH);
  assign mem_rd   = busy && !oob;
  assign mem_addr = busy ? addr_x[63:0] : '0;

  always_comb begin
    len0 = 4'd1;
    bad0 = 1'b0;
    unique case (mem_rdata[7:4])
      4'h0, 4'h1, 4'h9:        len0 = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:  len0 = 4'd2;
      4'h7, 4'h8:              len0 = 4'd9;
      4'h3, 4'h4, 4'h5:        len0 = 4'd10;
      default:                 bad0 = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= '0;
      k           <= '0;
      len         <= '0;
      Byte0       <= '0;
      Byte19      <= '0;
      instr_ready <= 1'b0;
      imem_error  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (req) begin
            base        <= pc;
            k           <= '0;
            Byte0       <= '0;
            Byte19      <= '0;
            imem_error  <= 1'b0;
            instr_ready <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (oob || mem_err) begin
            imem_error  <= 1'b1;
            instr_ready <= 1'b1;
            state       <= DONE;
          end else if (mem_valid) begin
            k <= k + 4'd1;
            if (k == 4'd0) begin
              Byte0 <= mem_rdata;
              len   <= len0;
              if (bad0) imem_error <= 1'b1;
              if (len0 == 4'd1) begin
                instr_ready <= 1'b1;
                state       <= DONE;
              end
            end else begin
              for (int i = 1; i < 10; i++)
                if (k == 4'(i)) Byte19[8*i-8 +: 8] <= mem_rdata;
              if (k + 4'd1 == len) begin
                instr_ready <= 1'b1;
                state       <= DONE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Randomized scoreboard bench for instr_prefetch: two instances
// (MEM_SIZE 1024 and 16) fetch the same pc from a shared memory image.
module tb_instr_prefetch;

  localparam int unsigned SZ0 = 1024;
  localparam int unsigned SZ1 = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req = 1'b0;
  logic [63:0]      pc = '0;
  logic [1:0][63:0] mem_addr;
  logic [1:0]       mem_rd;
  logic [1:0][7:0]  mem_rdata;
  logic [1:0]       mem_valid;
  logic [1:0]       mem_err;
  logic [1:0][7:0]  byte0;
  logic [1:0][71:0] byte19;
  logic [1:0]       ready;
  logic [1:0]       ierr;
  logic [1:0]       busy;

  always #5 clk = ~clk;

  instr_prefetch #(.MEM_SIZE(SZ0)) u0 (
    .clk(clk), .rst_n(rst_n), .pc(pc), .req(req),
    .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]),
    .mem_rdata(mem_rdata[0]), .mem_valid(mem_valid[0]),
    .mem_err(mem_err[0]), .Byte0(byte0[0]), .Byte19(byte19[0]),
    .instr_ready(ready[0]), .imem_error(ierr[0]), .busy(busy[0])
  );

  instr_prefetch #(.MEM_SIZE(SZ1)) u1 (
    .clk(clk), .rst_n(rst_n), .pc(pc), .req(req),
    .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]),
    .mem_rdata(mem_rdata[1]), .mem_valid(mem_valid[1]),
    .mem_err(mem_err[1]), .Byte0(byte0[1]), .Byte19(byte19[1]),
    .instr_ready(ready[1]), .imem_error(ierr[1]), .busy(busy[1])
  );

  typedef struct {
    logic [63:0] base;
    logic [7:0]  b0;
    logic [71:0] b19;
    bit          err;
    int          beats;
  } exp_t;

  logic [7:0]  mem_img [1024];
  exp_t        expq [2][$];
  logic [63:0] seen [2][$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] cur_pc = '0;
  int          maxw = 0;
  int          err_beat = 99;
  bit          pending [2];
  int          wcnt [2];
  int          wtgt [2];
  logic [63:0] last_addr [2];
  bit          prev [2];

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the bytes from base, stopping at the memory limit,
  // an injected fault, or the length given by the first byte.
  function automatic exp_t model(input logic [63:0] base,
                                 input int unsigned size, input int eb);
    exp_t        e;
    logic [7:0]  b [10];
    logic [64:0] a;
    int          len;
    foreach (b[j]) b[j] = 8'h00;
    e.base = base;
    e.err = 1'b0;
    e.beats = 0;
    len = 10;
    for (int k = 0; k < len; k++) begin
      a = {1'b0, base} + 65'(k);
      if (a >= 65'(size) || k == eb) begin
        e.err = 1'b1;
        break;
      end
      b[k] = mem_img[a[9:0]];
      e.beats++;
      if (k == 0) begin
        case (b[0][7:4])
          4'h0, 4'h1, 4'h9:       len = 1;
          4'h2, 4'h6, 4'hA, 4'hB: len = 2;
          4'h7, 4'h8:             len = 9;
          4'h3, 4'h4, 4'h5:       len = 10;
          default: begin
            len = 1;
            e.err = 1'b1;
          end
        endcase
      end
    end
    e.b0 = b[0];
    e.b19 = '0;
    for (int j = 1; j < 10; j++) e.b19[8*j-8 +: 8] = b[j];
    return e;
  endfunction

  // Memory responder: random wait states, fault on beat err_beat.
  initial begin
    mem_valid = '0;
    mem_err = '0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        mem_valid[i] = 1'b0;
        mem_err[i] = 1'b0;
        mem_rdata[i] = 8'($urandom);
        if (rst_n && mem_rd[i]) begin
          if (!pending[i]) begin
            pending[i] = 1'b1;
            wcnt[i] = 0;
            wtgt[i] = int'($urandom_range(0, maxw));
            last_addr[i] = mem_addr[i];
          end else begin
            chk($sformatf("addr_hold%0d", i), 160'(mem_addr[i]),
                160'(last_addr[i]));
          end
          if (wcnt[i] == wtgt[i]) begin
            pending[i] = 1'b0;
            if (int'(mem_addr[i] - cur_pc) == err_beat) begin
              mem_err[i] = 1'b1;
              mem_valid[i] = 1'($urandom);
            end else begin
              mem_valid[i] = 1'b1;
              mem_rdata[i] = mem_img[mem_addr[i][9:0]];
              seen[i].push_back(mem_addr[i]);
            end
          end else begin
            wcnt[i]++;
          end
        end else begin
          pending[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: on each rising instr_ready pop the expected result.
  initial begin
    exp_t e;
    prev[0] = 1'b0;
    prev[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          prev[i] = 1'b0;
        end else begin
          if (ready[i] && !prev[i]) begin
            if (expq[i].size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_ready%0d: got 1 expected 0", i);
            end else begin
              e = expq[i].pop_front();
              chk($sformatf("byte0_%0d@%0h", i, e.base),
                  160'(byte0[i]), 160'(e.b0));
              chk($sformatf("byte19_%0d@%0h", i, e.base),
                  160'(byte19[i]), 160'(e.b19));
              chk($sformatf("imem_error%0d@%0h", i, e.base),
                  160'(ierr[i]), 160'(e.err));
              chk($sformatf("beats%0d@%0h", i, e.base),
                  160'(seen[i].size()), 160'(e.beats));
              chk($sformatf("idle_rd%0d", i),
                  160'({busy[i], mem_rd[i]}), 160'(0));
              foreach (seen[i][j])
                chk($sformatf("addr%0d_%0d", i, j), 160'(seen[i][j]),
                    160'(e.base + 64'(j)));
            end
            seen[i].delete();
          end
          prev[i] = ready[i];
        end
      end
    end
  end

  task automatic run_txn(input logic [63:0] p, input int mw, input int eb,
                         output int lat);
    @(negedge clk);
    cur_pc = p;
    maxw = mw;
    err_beat = eb;
    pc = p;
    expq[0].push_back(model(p, SZ0, eb));
    expq[1].push_back(model(p, SZ1, eb));
    req = 1'b1;
    lat = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      // req while both are fetching must be ignored
      req = (busy[0] && busy[1]) ? 1'($urandom) : 1'b0;
      if (req) pc = {32'($urandom), 32'($urandom)};
      if (ready[0] && lat == 0) lat = c;
      if (ready[0] && ready[1]) break;
    end
    req = 1'b0;
    if (!(ready[0] && ready[1])) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout@%0h: got ready=%b expected 11", p, ready);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_ctl%0d", tag, i),
          160'({mem_rd[i], ready[i], ierr[i], busy[i]}), 160'(0));
      chk($sformatf("%s_addr%0d", tag, i), 160'(mem_addr[i]), 160'(0));
      chk($sformatf("%s_data%0d", tag, i),
          160'({byte0[i], byte19[i]}), 160'(0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [63:0] p;
    foreach (mem_img[j]) mem_img[j] = 8'($urandom);
    mem_img[0] = 8'h30;
    mem_img[1] = 8'hF2;
    mem_img[2] = 8'h0A;
    for (int j = 3; j < 10; j++) mem_img[j] = 8'h00;
    mem_img[12] = 8'h70;
    mem_img[20] = 8'h60;
    mem_img[21] = 8'h23;
    mem_img[40] = 8'hC0;
    mem_img[60] = 8'h50;

    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    run_txn(64'd0, 0, 99, lat);
    chk("irmovq_latency", 160'(lat), 160'(11));
    run_txn(64'd20, 0, 99, lat);
    chk("addq_latency", 160'(lat), 160'(3));
    chk("addq_rd_low", 160'(mem_rd[0]), 160'(0));
    run_txn(64'd5, 3, 99, lat);
    run_txn(64'd12, 1, 99, lat);
    run_txn(64'd40, 0, 99, lat);
    run_txn(64'd60, 1, 3, lat);

    // reset between edges in the middle of a fetch
    @(negedge clk);
    cur_pc = '0;
    maxw = 0;
    err_beat = 99;
    pc = '0;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    for (int i = 0; i < 2; i++) begin
      expq[i].delete();
      seen[i].delete();
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("no_ready_after_reset", 160'({ready, busy}), 160'(0));
    run_txn(64'd0, 0, 99, lat);
    chk("refetch_latency", 160'(lat), 160'(11));

    for (int t = 0; t < 150; t++) begin
      case ($urandom % 4)
        0: p = 64'($urandom_range(0, 1023));
        1: p = 64'($urandom_range(0, 20));
        2: p = 64'($urandom_range(1012, 1025));
        default: p = 64'hFFFF_FFFF_FFFF_FFF6 + 64'($urandom_range(0, 9));
      endcase
      run_txn(p, int'($urandom_range(0, 3)),
              ($urandom % 4 == 0) ? int'($urandom_range(0, 9)) : 99, lat);
    end

    repeat (3) @(negedge clk);
    chk("queue0_empty", 160'(expq[0].size()), 160'(0));
    chk("queue1_empty", 160'(expq[1].size()), 160'(0));
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
